vec_seq_ctrl: RTL and testbench

Parametrised sequencer for the vector datapath. It drives the per-lane enables for operand loads (A, B), product capture, two reduction adder stages and the final-output registers. It sits where the fixed 4-lane, free-running controller sat. Unlike that controller, it runs only on request, supports any lane count, and adds stall, abort, continuous mode, a done pulse and a completed-pass counter.

---
 rtl/vec_ctrl_pkg.sv | 30 +++
 rtl/lane_onehot_dec.sv | 17 +
 rtl/vec_seq_ctrl.sv | 102 ++++++++++
 tb/tb_vec_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_ctrl_pkg.sv
// Shared types for the vector datapath sequencer: phase encoding, phase order
// and the default pass-counter width.
package vec_ctrl_pkg;

    localparam int CNTW_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MUL    = 3'd3,
        ADD1   = 3'd4,
        ADD2   = 3'd5,
        FIN    = 3'd6
    } vec_phase_t;

    // FIN maps to IDLE here; the restart-or-stop choice after FIN is made by the caller.
    function automatic vec_phase_t phase_next(input vec_phase_t ph);
        case (ph)
            IDLE:    phase_next = LOAD_A;
            LOAD_A:  phase_next = LOAD_B;
            LOAD_B:  phase_next = MUL;
            MUL:     phase_next = ADD1;
            ADD1:    phase_next = ADD2;
            ADD2:    phase_next = FIN;
            default: phase_next = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lane_onehot_dec.sv
// Lane index to one-hot decoder; all-zero output when valid is low.
module lane_onehot_dec #(
    parameter  int LANES = 4,
    localparam int IDXW  = $clog2(LANES)
) (
    input  logic [IDXW-1:0]  idx,
    input  logic             valid,
    output logic [LANES-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign onehot[gi] = valid && (idx == IDXW'(gi));
        end
    endgenerate

endmodule

// File: rtl/vec_seq_ctrl.sv
// On-request sequencer for the vector datapath: walks LOAD_A..FIN one lane per
// cycle, with stall, abort, continuous mode, done pulse and a pass counter.
module vec_seq_ctrl
    import vec_ctrl_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int CNTW  = CNTW_DEFAULT,
    localparam int IDXW  = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_cont,
    input  logic             stall,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  lane_idx,
    output logic [LANES-1:0] en_a,
    output logic [LANES-1:0] en_b,
    output logic [LANES-1:0] en_add1,
    output logic [LANES-1:0] en_add2,
    output logic [LANES-1:0] en_f,
    output logic             save_c,
    output logic [CNTW-1:0]  pass_cnt
);

    vec_phase_t      ph_reg, ph_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;

    logic             active;
    logic             last_lane;
    logic             go;
    logic             dec_valid;
    logic [LANES-1:0] dec_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_reg  <= IDLE;
            idx_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ph_reg  <= ph_next;
            idx_reg <= idx_next;
            cnt_reg <= cnt_next;
        end
    end

    assign busy      = (ph_reg != IDLE);
    assign active    = busy && !stall;
    assign last_lane = (idx_reg == IDXW'(LANES - 1));
    assign go        = start || mode_cont;
    assign done      = active && !abort && (ph_reg == FIN) && last_lane;

    always_comb begin
        ph_next  = ph_reg;
        idx_next = idx_reg;
        cnt_next = cnt_reg;
        if (abort) begin
            ph_next  = IDLE;
            idx_next = '0;
        end else if (ph_reg == IDLE) begin
            if (go) begin
                ph_next  = LOAD_A;
                idx_next = '0;
            end
        end else if (active) begin
            if (last_lane) begin
                idx_next = '0;
                if (ph_reg == FIN) begin
                    cnt_next = cnt_reg + CNTW'(1);
                    ph_next  = go ? LOAD_A : IDLE;
                end else begin
                    ph_next = phase_next(ph_reg);
                end
            end else begin
                idx_next = idx_reg + IDXW'(1);
            end
        end
    end

    // One shared decoder; its output is steered to whichever phase is active.
    assign dec_valid = active && (ph_reg != MUL);

    lane_onehot_dec #(.LANES(LANES)) u_dec (
        .idx    (idx_reg),
        .valid  (dec_valid),
        .onehot (dec_onehot)
    );

    assign en_a    = (ph_reg == LOAD_A) ? dec_onehot : '0;
    assign en_b    = (ph_reg == LOAD_B) ? dec_onehot : '0;
    assign en_add1 = (ph_reg == ADD1)   ? dec_onehot : '0;
    assign en_add2 = (ph_reg == ADD2)   ? dec_onehot : '0;
    assign en_f    = (ph_reg == FIN)    ? dec_onehot : '0;
    assign save_c  = active && (ph_reg == MUL);

    assign lane_idx = idx_reg;
    assign pass_cnt = cnt_reg;

endmodule

// File: tb/tb_vec_seq_ctrl.sv
// Two sequencers (4 lanes / 16-bit count, 5 lanes / 2-bit count) driven by the
// same stimulus and compared every cycle against a pass-position reference model.
module tb_vec_seq_ctrl;

    localparam int LA = 4, CA = 16;
    localparam int LB = 5, CB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0, start = 1'b0, mode_cont = 1'b0, stall = 1'b0, abort = 1'b0;

    logic          busy_a, done_a, save_c_a;
    logic [1:0]    lane_idx_a;
    logic [LA-1:0] en_a_a, en_b_a, en_add1_a, en_add2_a, en_f_a;
    logic [CA-1:0] pass_cnt_a;

    logic          busy_b, done_b, save_c_b;
    logic [2:0]    lane_idx_b;
    logic [LB-1:0] en_a_b, en_b_b, en_add1_b, en_add2_b, en_f_b;
    logic [CB-1:0] pass_cnt_b;

    always #5 clk = ~clk;

    vec_seq_ctrl #(.LANES(LA), .CNTW(CA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .stall(stall), .abort(abort), .busy(busy_a), .done(done_a),
        .lane_idx(lane_idx_a), .en_a(en_a_a), .en_b(en_b_a), .en_add1(en_add1_a),
        .en_add2(en_add2_a), .en_f(en_f_a), .save_c(save_c_a), .pass_cnt(pass_cnt_a)
    );

    vec_seq_ctrl #(.LANES(LB), .CNTW(CB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .stall(stall), .abort(abort), .busy(busy_b), .done(done_b),
        .lane_idx(lane_idx_b), .en_a(en_a_b), .en_b(en_b_b), .en_add1(en_add1_b),
        .en_add2(en_add2_b), .en_f(en_f_b), .save_c(save_c_b), .pass_cnt(pass_cnt_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference: pos = -1 when idle, else the cycle number within a pass (0 .. 6*L-1).
    int pos[2];
    int cnt[2];
    int lanes[2];
    int cmask[2];
    int last_done[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic b, input logic d,
                              input logic [31:0] li, input logic [31:0] pc,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] ef, input logic sc);
        int L, ph, ix;
        bit bz, act, exp_done;
        logic [31:0] oh;
        string p;
        L   = lanes[i];
        bz  = (pos[i] >= 0) && rst_n;
        act = bz && !stall;
        ph  = bz ? pos[i] / L : -1;
        ix  = bz ? pos[i] % L : 0;
        oh  = act ? (32'd1 << ix) : 32'd0;
        exp_done = act && !abort && (pos[i] == 6 * L - 1);
        p = $sformatf("%s c%0d", (i == 0) ? "L4" : "L5", cyc);
        check({p, " busy"},     32'(b),  32'(bz));
        check({p, " done"},     32'(d),  32'(exp_done));
        check({p, " lane_idx"}, li,      ix);
        check({p, " pass_cnt"}, pc,      cnt[i]);
        check({p, " en_a"},     ea,      (ph == 0) ? oh : 32'd0);
        check({p, " en_b"},     eb,      (ph == 1) ? oh : 32'd0);
        check({p, " save_c"},   32'(sc), 32'(act && ph == 2));
        check({p, " en_add1"},  e1,      (ph == 3) ? oh : 32'd0);
        check({p, " en_add2"},  e2,      (ph == 4) ? oh : 32'd0);
        check({p, " en_f"},     ef,      (ph == 5) ? oh : 32'd0);
        check({p, " onehot"},
              32'(($countones(ea) + $countones(eb) + $countones(e1) +
                   $countones(e2) + $countones(ef)) <= 1), 32'd1);
    endtask

    task automatic check_all();
        check_inst(0, busy_a, done_a, 32'(lane_idx_a), 32'(pass_cnt_a), 32'(en_a_a),
                   32'(en_b_a), 32'(en_add1_a), 32'(en_add2_a), 32'(en_f_a), save_c_a);
        check_inst(1, busy_b, done_b, 32'(lane_idx_b), 32'(pass_cnt_b), 32'(en_a_b),
                   32'(en_b_b), 32'(en_add1_b), 32'(en_add2_b), 32'(en_f_b), save_c_b);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (abort) begin
                pos[i] = -1;
            end else if (pos[i] < 0) begin
                if (start || mode_cont) pos[i] = 0;
            end else if (!stall) begin
                if (pos[i] == 6 * lanes[i] - 1) begin
                    cnt[i] = (cnt[i] + 1) & cmask[i];
                    pos[i] = (start || mode_cont) ? 0 : -1;
                end else begin
                    pos[i] = pos[i] + 1;
                end
            end
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the next one.
    task automatic cycle(input logic s, input logic m, input logic st, input logic ab);
        start = s; mode_cont = m; stall = st; abort = ab;
        @(negedge clk);
        check_all();
        if (done_a) last_done[0] = cyc;
        if (done_b) last_done[1] = cyc;
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1;
            cnt[i] = 0;
        end
        #1;
        check_all();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        int t0;
        lanes[0] = LA; lanes[1] = LB;
        cmask[0] = (1 << CA) - 1; cmask[1] = (1 << CB) - 1;
        pos[0] = -1; pos[1] = -1; cnt[0] = 0; cnt[1] = 0;
        @(posedge clk);
        #1;
        do_reset(3);
        idle(2);

        // Single start: done at T+6L for each lane count.
        last_done[0] = -1; last_done[1] = -1;
        t0 = cyc;
        cycle(1, 0, 0, 0);
        idle(32);
        check("done_cycle L4", 32'(last_done[0] - t0), 32'd24);
        check("done_cycle L5", 32'(last_done[1] - t0), 32'd30);

        // Continuous mode: three L5 passes back to back, then drain.
        t0 = cyc;
        for (int k = 0; k < 90; k++) cycle(0, 1, 0, 0);
        check("cont_done L5", 32'(last_done[1] - t0), 32'd60);
        idle(32);

        // Stall for three cycles at L4 en_b[1]; done slips by three cycles.
        last_done[0] = -1;
        t0 = cyc;
        cycle(1, 0, 0, 0);
        for (int k = 1; k <= 32; k++) cycle(0, 0, (k >= 6 && k <= 8), 0);
        check("stall_done L4", 32'(last_done[0] - t0), 32'd27);
        idle(4);

        // Abort during L4 ADD1 lane 2, then a fresh full pass.
        t0 = cyc;
        cycle(1, 0, 0, 0);
        for (int k = 1; k <= 20; k++) cycle(0, 0, 0, (k == 15));
        last_done[0] = -1;
        t0 = cyc;
        cycle(1, 0, 0, 0);
        idle(32);
        check("after_abort L4", 32'(last_done[0] - t0), 32'd24);

        // Abort with the last L4 FIN cycle while start is high.
        last_done[0] = -1;
        t0 = cyc;
        cycle(1, 0, 0, 0);
        for (int k = 1; k <= 23; k++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 1);
        check("abort_fin done L4", 32'(last_done[0]), 32'hFFFF_FFFF);
        idle(8);

        // Reset mid-MUL.
        cycle(1, 0, 0, 0);
        idle(9);
        do_reset(2);
        idle(2);

        // Four L5 passes from reset wrap the 2-bit counter to 0.
        t0 = cyc;
        for (int k = 0; k < 120; k++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("wrap L5", 32'(pass_cnt_b), 32'd0);
        idle(32);

        // Randomized stimulus.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 2),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
